// File: rtl/display_pkg.sv
// Shared types for the serialized-pixel capture path: FSM states,
// component/pixel widths and the reassembled pixel layout.
package display_pkg;

  localparam int PIX_W  = 24;
  localparam int COMP_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_VB  = 3'd1,
    VBLANK   = 3'd2,
    HBLANK   = 3'd3,
    CAP_R    = 3'd4,
    CAP_G    = 3'd5,
    CAP_B    = 3'd6,
    LINE_END = 3'd7
  } cap_state_e;

  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/display_capture_pixel_assembler.sv
// Three-slot component latch: holds R and G, presents {R,G,B} with B taken
// straight from the input so the caller can register it on the B slot.
module pixel_assembler
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              lat_r,
  input  logic              lat_g,
  input  logic              lat_b,
  input  logic [COMP_W-1:0] comp,
  output pixel_t            pixel,
  output logic              valid
);

  logic [COMP_W-1:0] r_q;
  logic [COMP_W-1:0] g_q;
  logic              have_r_q;
  logic              have_g_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q      <= '0;
      g_q      <= '0;
      have_r_q <= 1'b0;
      have_g_q <= 1'b0;
    end else if (clr) begin
      have_r_q <= 1'b0;
      have_g_q <= 1'b0;
    end else begin
      if (lat_r) begin
        r_q      <= comp;
        have_r_q <= 1'b1;
        have_g_q <= 1'b0;
      end
      if (lat_g) begin
        g_q      <= comp;
        have_g_q <= have_r_q;
      end
      if (lat_b) begin
        have_r_q <= 1'b0;
        have_g_q <= 1'b0;
      end
    end
  end

  // Valid only when a complete R,G pair precedes this B slot.
  assign pixel = '{r: r_q, g: g_q, b: comp};
  assign valid = lat_b & have_g_q;

endmodule

// File: rtl/display_capture.sv
// Capture FSM for the R,G,B serialized pixel stream: reassembles pixels,
// writes them with a linear address and flags phase/geometry errors.
module display_capture
  import display_pkg::*;
#(
  parameter int ACT_PX    = 640,
  parameter int ACT_LINES = 480,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_vb,
  input  logic              sync_hb,
  input  logic              blank,
  input  logic [COMP_W-1:0] data_in,
  input  logic              err_clr,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [PIX_W-1:0]  pix_data,
  output logic              line_done,
  output logic              frame_done,
  output logic              err_phase,
  output logic              err_geom,
  output logic [9:0]        line_cnt
);

  localparam int              PX_W    = $clog2(ACT_PX + 2);
  localparam logic [PX_W-1:0] PX_FULL = PX_W'(ACT_PX);
  localparam logic [PX_W-1:0] PX_MAX  = PX_W'(ACT_PX + 1);
  localparam logic [9:0]      LINES   = 10'(ACT_LINES);

  cap_state_e        state_q, state_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [9:0]        line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_we_q, pix_we_d;
  logic              line_done_q, line_done_d;
  logic              frame_done_q, frame_done_d;
  logic              err_phase_q, err_phase_d;
  logic              err_geom_q, err_geom_d;

  logic              lat_r, lat_g, lat_b, asm_clr, asm_valid;
  pixel_t            asm_pixel;
  logic              in_cap, end_slot, phase_err, geom_err;
  logic [9:0]        line_inc;

  pixel_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .clr   (asm_clr),
    .lat_r (lat_r),
    .lat_g (lat_g),
    .lat_b (lat_b),
    .comp  (data_in),
    .pixel (asm_pixel),
    .valid (asm_valid)
  );

  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    line_d       = line_q;
    addr_d       = addr_q;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    pix_we_d     = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    lat_r        = 1'b0;
    lat_g        = 1'b0;
    lat_b        = 1'b0;
    asm_clr      = 1'b0;
    phase_err    = 1'b0;
    geom_err     = 1'b0;
    in_cap       = (state_q == CAP_R) || (state_q == CAP_G) || (state_q == CAP_B);
    end_slot     = blank | sync_hb | sync_vb;
    line_inc     = (line_q == 10'h3FF) ? line_q : line_q + 10'd1;

    if (!en) begin
      state_d = IDLE;
      px_d    = '0;
      line_d  = '0;
      addr_d  = '0;
      asm_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE:     state_d = WAIT_VB;
        WAIT_VB:  state_d = WAIT_VB;
        VBLANK, LINE_END: begin
          if (sync_hb) state_d = HBLANK;
        end
        HBLANK: begin
          if (!end_slot) begin
            lat_r   = 1'b1;
            state_d = CAP_G;
          end
        end
        CAP_R: begin
          if (!end_slot) begin
            lat_r   = 1'b1;
            state_d = CAP_G;
          end
        end
        CAP_G: begin
          if (!end_slot) begin
            lat_g   = 1'b1;
            state_d = CAP_B;
          end
        end
        CAP_B: begin
          if (!end_slot) begin
            lat_b   = 1'b1;
            state_d = CAP_R;
            px_d    = (px_q == PX_MAX) ? px_q : px_q + PX_W'(1);
            if (asm_valid && px_q < PX_FULL && line_q < LINES) begin
              pix_we_d   = 1'b1;
              pix_addr_d = addr_q;
              pix_data_d = asm_pixel;
              addr_d     = addr_q + ADDR_W'(1);
            end else begin
              geom_err = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // Any marker or blank inside a pixel run terminates the line.
      if (in_cap && end_slot) begin
        phase_err    = (state_q != CAP_R);
        geom_err     = (px_q != PX_FULL);
        asm_clr      = 1'b1;
        line_done_d  = 1'b1;
        line_d       = line_inc;
        frame_done_d = (line_inc == LINES);
        px_d         = '0;
        state_d      = sync_hb ? HBLANK : LINE_END;
      end

      // Frame restart; a line ended by this same slot has already been counted.
      if (sync_vb && state_q != IDLE) begin
        if (line_d != 10'd0 && line_d < LINES) geom_err = 1'b1;
        line_d  = '0;
        px_d    = '0;
        addr_d  = '0;
        asm_clr = 1'b1;
        state_d = sync_hb ? HBLANK : VBLANK;
      end
    end

    err_phase_d = (err_phase_q & ~err_clr) | phase_err;
    err_geom_d  = (err_geom_q & ~err_clr) | geom_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      px_q         <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      pix_we_q     <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_phase_q  <= 1'b0;
      err_geom_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      pix_we_q     <= pix_we_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      err_phase_q  <= err_phase_d;
      err_geom_q   <= err_geom_d;
    end
  end

  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign err_phase  = err_phase_q;
  assign err_geom   = err_geom_q;
  assign line_cnt   = line_q;

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture with a 4x2 active area: expected
// writes are queued as slots are driven and matched when pix_we appears.
module tb_display_capture;

  localparam int NPX = 4;
  localparam int NLN = 2;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          sync_vb = 1'b0;
  logic          sync_hb = 1'b0;
  logic          blank = 1'b1;
  logic [7:0]    data_in = '0;
  logic          err_clr = 1'b0;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data;
  logic          line_done, frame_done, err_phase, err_geom;
  logic [9:0]    line_cnt;

  display_capture #(.ACT_PX(NPX), .ACT_LINES(NLN), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sync_vb    (sync_vb),
    .sync_hb    (sync_hb),
    .blank      (blank),
    .data_in    (data_in),
    .err_clr    (err_clr),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .line_done  (line_done),
    .frame_done (frame_done),
    .err_phase  (err_phase),
    .err_geom   (err_geom),
    .line_cnt   (line_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          writes_seen = 0;
  int          ld_cnt = 0;
  int          fd_cnt = 0;
  int          fd_with_ld = 0;
  int          m_addr = 0;
  int          m_line = 0;
  logic [7:0]  seed = 8'h10;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (line_done) ld_cnt++;
      if (frame_done) fd_cnt++;
      if (frame_done && line_done) fd_with_ld++;
      if (pix_we) begin
        exp_t e;
        writes_seen++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%0d data=%06h, required no write", pix_addr, pix_data);
        end else begin
          e = exp_q.pop_front();
          if (pix_addr !== e.addr || pix_data !== e.data) begin
            miscompares++;
            $display("FAIL write: addr=%0d data=%06h, required addr=%0d data=%06h",
                     pix_addr, pix_data, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic slot(input logic b, input logic hb, input logic vb, input logic [7:0] d);
    blank   = b;
    sync_hb = hb;
    sync_vb = vb;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    writes_seen = 0;
    ld_cnt      = 0;
    fd_cnt      = 0;
    fd_with_ld  = 0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    slot(1'b1, 1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
  endtask

  // Two vertical-blank lines then the horizontal blank opening line 0.
  task automatic frame_start();
    m_addr = 0;
    m_line = 0;
    slot(1'b1, 1'b0, 1'b1, 8'h00);
    repeat (5) slot(1'b1, 1'b0, 1'b0, 8'h00);
    slot(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (5) slot(1'b1, 1'b0, 1'b0, 8'h00);
    slot(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (2) slot(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // npx pixels; cut>=0 blanks the G slot of that pixel; live=0 expects no writes.
  task automatic send_line(input int npx, input int cut, input bit live);
    int         px;
    logic [7:0] n0, n1, n2;
    px = 0;
    for (int p = 0; p < npx; p++) begin
      n0 = seed;
      n1 = seed + 8'd1;
      n2 = seed + 8'd2;
      seed = seed + 8'd3;
      slot(1'b0, 1'b0, 1'b0, n0);
      if (p == cut) begin
        slot(1'b1, 1'b0, 1'b0, 8'h00);
        break;
      end
      slot(1'b0, 1'b0, 1'b0, n1);
      slot(1'b0, 1'b0, 1'b0, n2);
      if (live && px < NPX && m_line < NLN) begin
        exp_q.push_back('{AW'(m_addr), {n0, n1, n2}});
        m_addr++;
      end
      px++;
    end
    if (live) m_line++;
    slot(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (2) slot(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_writes: %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    vectors += 8;
    if (pix_we !== 1'b0)     begin miscompares++; $display("FAIL rst_pix_we: %b, required 0", pix_we); end
    if (pix_addr !== '0)     begin miscompares++; $display("FAIL rst_pix_addr: %0d, required 0", pix_addr); end
    if (pix_data !== '0)     begin miscompares++; $display("FAIL rst_pix_data: %06h, required 0", pix_data); end
    if (line_done !== 1'b0)  begin miscompares++; $display("FAIL rst_line_done: %b, required 0", line_done); end
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: %b, required 0", frame_done); end
    if (err_phase !== 1'b0)  begin miscompares++; $display("FAIL rst_err_phase: %b, required 0", err_phase); end
    if (err_geom !== 1'b0)   begin miscompares++; $display("FAIL rst_err_geom: %b, required 0", err_geom); end
    if (line_cnt !== '0)     begin miscompares++; $display("FAIL rst_line_cnt: %0d, required 0", line_cnt); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    slot(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_nominal();
    clear_counts();
    frame_start();
    send_line(4, -1, 1'b1);
    send_line(4, -1, 1'b1);
    check_drained("nominal");
    vectors += 6;
    if (writes_seen != 8) begin miscompares++; $display("FAIL nominal_writes: %0d, required 8", writes_seen); end
    if (ld_cnt != 2)      begin miscompares++; $display("FAIL nominal_line_done: %0d, required 2", ld_cnt); end
    if (fd_with_ld != 1 || fd_cnt != 1) begin
      miscompares++; $display("FAIL nominal_frame_done: %0d (with line_done %0d), required 1", fd_cnt, fd_with_ld);
    end
    if (line_cnt !== 10'd2) begin miscompares++; $display("FAIL nominal_line_cnt: %0d, required 2", line_cnt); end
    if (err_phase !== 1'b0) begin miscompares++; $display("FAIL nominal_err_phase: %b, required 0", err_phase); end
    if (err_geom !== 1'b0)  begin miscompares++; $display("FAIL nominal_err_geom: %b, required 0", err_geom); end
  endtask

  task automatic test_phase_error();
    clear_counts();
    frame_start();
    send_line(4, 1, 1'b1);
    send_line(4, -1, 1'b1);
    check_drained("phase");
    vectors += 4;
    if (writes_seen != 5)   begin miscompares++; $display("FAIL phase_writes: %0d, required 5", writes_seen); end
    if (err_phase !== 1'b1) begin miscompares++; $display("FAIL phase_err_phase: %b, required 1", err_phase); end
    if (err_geom !== 1'b1)  begin miscompares++; $display("FAIL phase_err_geom: %b, required 1", err_geom); end
    if (fd_cnt != 1)        begin miscompares++; $display("FAIL phase_frame_done: %0d, required 1", fd_cnt); end
    clear_errors();
    vectors += 2;
    if (err_phase !== 1'b0) begin miscompares++; $display("FAIL clr_err_phase: %b, required 0", err_phase); end
    if (err_geom !== 1'b0)  begin miscompares++; $display("FAIL clr_err_geom: %b, required 0", err_geom); end
  endtask

  task automatic test_long_line();
    clear_counts();
    frame_start();
    send_line(5, -1, 1'b1);
    send_line(4, -1, 1'b1);
    check_drained("long");
    vectors += 3;
    if (writes_seen != 8)   begin miscompares++; $display("FAIL long_writes: %0d, required 8", writes_seen); end
    if (err_geom !== 1'b1)  begin miscompares++; $display("FAIL long_err_geom: %b, required 1", err_geom); end
    if (err_phase !== 1'b0) begin miscompares++; $display("FAIL long_err_phase: %b, required 0", err_phase); end
    clear_errors();
  endtask

  task automatic test_early_vb();
    clear_counts();
    frame_start();
    send_line(4, -1, 1'b1);
    vectors++;
    if (err_geom !== 1'b0) begin miscompares++; $display("FAIL early_vb_pre_geom: %b, required 0", err_geom); end
    frame_start();
    vectors++;
    if (err_geom !== 1'b1) begin miscompares++; $display("FAIL early_vb_err_geom: %b, required 1", err_geom); end
    send_line(4, -1, 1'b1);
    send_line(4, -1, 1'b1);
    check_drained("early_vb");
    vectors++;
    if (writes_seen != 12) begin miscompares++; $display("FAIL early_vb_writes: %0d, required 12", writes_seen); end
    clear_errors();
  endtask

  task automatic test_en_drop();
    clear_counts();
    frame_start();
    send_line(4, -1, 1'b1);
    slot(1'b0, 1'b0, 1'b0, 8'hA0);
    en = 1'b0;
    slot(1'b0, 1'b0, 1'b0, 8'hA1);
    repeat (4) slot(1'b0, 1'b0, 1'b0, 8'hA2);
    vectors += 2;
    if (line_cnt !== 10'd0) begin miscompares++; $display("FAIL en_drop_line_cnt: %0d, required 0", line_cnt); end
    if (err_geom !== 1'b0)  begin miscompares++; $display("FAIL en_drop_err_geom: %b, required 0", err_geom); end
    en = 1'b1;
    slot(1'b1, 1'b0, 1'b0, 8'h00);
    send_line(4, -1, 1'b0);
    send_line(4, -1, 1'b0);
    vectors++;
    if (writes_seen != 4) begin miscompares++; $display("FAIL en_drop_pre_vb_writes: %0d, required 4", writes_seen); end
    frame_start();
    send_line(4, -1, 1'b1);
    send_line(4, -1, 1'b1);
    check_drained("en_drop");
    vectors++;
    if (writes_seen != 12) begin miscompares++; $display("FAIL en_drop_writes: %0d, required 12", writes_seen); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    frame_start();
    send_line(4, -1, 1'b1);
    slot(1'b0, 1'b0, 1'b0, 8'hC0);
    slot(1'b0, 1'b0, 1'b0, 8'hC1);
    blank   = 1'b0;
    data_in = 8'hC2;
    #2;
    reset = 1'b1;
    #1;
    vectors += 3;
    if (line_cnt !== 10'd0) begin miscompares++; $display("FAIL mid_rst_line_cnt: %0d, required 0", line_cnt); end
    if (pix_addr !== '0)    begin miscompares++; $display("FAIL mid_rst_pix_addr: %0d, required 0", pix_addr); end
    if (pix_data !== '0)    begin miscompares++; $display("FAIL mid_rst_pix_data: %06h, required 0", pix_data); end
    @(posedge clk);
    #1;
    vectors++;
    if (pix_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_pix_we: %b, required 0", pix_we); end
    #2;
    reset = 1'b0;
    repeat (4) slot(1'b0, 1'b0, 1'b0, 8'hC3);
    check_drained("mid_rst");
    vectors++;
    if (writes_seen != 4) begin miscompares++; $display("FAIL mid_rst_writes: %0d, required 4", writes_seen); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_phase_error();
    test_long_line();
    test_early_vb();
    test_en_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
